// File: rtl/alu_sched_pkg.sv
// Shared definitions for the round-robin ALU scheduler and the ALU it feeds.
// Contents: FSM state encoding, default datapath widths, ALU opcode constants.
package alu_sched_pkg;

  localparam int unsigned NB_DATA_DEF = 8;
  localparam int unsigned NB_OP_DEF   = 6;
  localparam int unsigned NB_RES_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Opcodes understood by the downstream ALU
  localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP_DEF-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: picks one requester from req_i.
// Default: round-robin search starting at ptr_i, wrapping N_REQ-1 -> 0.
// With ALU_RR_SCHED_FIXED_PRIO_EN defined: lowest index wins, ptr_i ignored.
// Ports:
//   req_i  - request vector
//   ptr_i  - index of the highest-priority requester
//   gnt_o  - one-hot grant (all zero when nothing requests)
//   idx_o  - index of the granted requester
//   any_o  - a grant is being made
module rr_arbiter
  import alu_sched_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned NB_ID = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [NB_ID-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [NB_ID-1:0] idx_o,
  output logic             any_o
);

`ifdef ALU_RR_SCHED_FIXED_PRIO_EN

  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  // Lowest set bit wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!any_o && req_i[NB_ID'(i)]) begin
        any_o              = 1'b1;
        gnt_o[NB_ID'(i)]   = 1'b1;
        idx_o              = NB_ID'(i);
      end
    end
  end

`else

  localparam int unsigned NB_W = NB_ID + 1;

  logic [NB_W-1:0]  sum;
  logic [NB_ID-1:0] cand;

  // Walk ptr_i, ptr_i+1, ... modulo N_REQ; first requester found wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr_i} + NB_W'(i);
      if (sum >= NB_W'(N_REQ)) begin
        sum = sum - NB_W'(N_REQ);
      end
      cand = sum[NB_ID-1:0];
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

`endif

endmodule

// File: rtl/alu_rr_sched.sv
// Shares one combinational ALU among N_REQ requesters.
// IDLE grants one request and registers its operands towards the ALU, EXEC
// samples the ALU result, RESP presents it tagged with the requester index
// until the consumer accepts it.
// Config macro: ALU_RR_SCHED_FIXED_PRIO_EN selects fixed (lowest index)
// priority and removes the round-robin pointer.
// Ports:
//   i_clk, i_rst                 - clock, async active-low reset
//   i_req_valid / o_req_ready    - per-requester handshake (ready is a one-hot pulse)
//   i_req_data_a/b, i_req_op     - packed per-requester operands and opcode
//   o_alu_data_a/b, o_alu_op     - registered ALU inputs
//   i_alu_result                 - ALU output
//   o_rsp_valid/id/result        - response channel, i_rsp_ready accepts
module alu_rr_sched
  import alu_sched_pkg::*;
#(
  parameter  int unsigned N_REQ   = 4,
  parameter  int unsigned NB_DATA = alu_sched_pkg::NB_DATA_DEF,
  parameter  int unsigned NB_OP   = alu_sched_pkg::NB_OP_DEF,
  parameter  int unsigned NB_RES  = alu_sched_pkg::NB_RES_DEF,
  localparam int unsigned NB_ID   = $clog2(N_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [N_REQ*NB_DATA-1:0] i_req_data_a,
  input  logic [N_REQ*NB_DATA-1:0] i_req_data_b,
  input  logic [N_REQ*NB_OP-1:0]   i_req_op,
  output logic [N_REQ-1:0]         o_req_ready,
  output logic [NB_DATA-1:0]       o_alu_data_a,
  output logic [NB_DATA-1:0]       o_alu_data_b,
  output logic [NB_OP-1:0]         o_alu_op,
  input  logic [NB_RES-1:0]        i_alu_result,
  output logic                     o_rsp_valid,
  output logic [NB_ID-1:0]         o_rsp_id,
  output logic [NB_RES-1:0]        o_rsp_result,
  input  logic                     i_rsp_ready
);

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] alu_a_q, alu_a_d;
  logic [NB_DATA-1:0] alu_b_q, alu_b_d;
  logic [NB_OP-1:0]   alu_op_q, alu_op_d;
  logic [NB_ID-1:0]   rsp_id_q, rsp_id_d;
  logic [NB_RES-1:0]  rsp_res_q, rsp_res_d;
  logic               rsp_valid_q, rsp_valid_d;

  logic [NB_ID-1:0]   arb_ptr;
  logic [N_REQ-1:0]   win_gnt;
  logic [NB_ID-1:0]   win_idx;
  logic               win_any;

  // Unpack the flat request buses
  logic [NB_DATA-1:0] req_a  [N_REQ];
  logic [NB_DATA-1:0] req_b  [N_REQ];
  logic [NB_OP-1:0]   req_op [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign req_a[k]  = i_req_data_a[k*NB_DATA +: NB_DATA];
    assign req_b[k]  = i_req_data_b[k*NB_DATA +: NB_DATA];
    assign req_op[k] = i_req_op[k*NB_OP +: NB_OP];
  end

`ifdef ALU_RR_SCHED_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [NB_ID-1:0] ptr_q, ptr_d;
  assign arb_ptr = ptr_q;
`endif

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req_i (i_req_valid),
    .ptr_i (arb_ptr),
    .gnt_o (win_gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  // Accept pulse in the grant cycle only; held off while reset is asserted
  assign o_req_ready = (state_q == IDLE && i_rst) ? win_gnt : '0;

  // Next-state and datapath register update
  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_id_d    = rsp_id_q;
    rsp_res_d   = rsp_res_q;
    rsp_valid_d = rsp_valid_q;
`ifndef ALU_RR_SCHED_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_any) begin
          alu_a_d  = req_a[win_idx];
          alu_b_d  = req_b[win_idx];
          alu_op_d = req_op[win_idx];
          rsp_id_d = win_idx;
          state_d  = EXEC;
`ifndef ALU_RR_SCHED_FIXED_PRIO_EN
          ptr_d    = (win_idx == NB_ID'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif
        end
      end
      EXEC: begin
        rsp_res_d   = i_alu_result;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_id_q    <= '0;
      rsp_res_q   <= '0;
      rsp_valid_q <= 1'b0;
`ifndef ALU_RR_SCHED_FIXED_PRIO_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_id_q    <= rsp_id_d;
      rsp_res_q   <= rsp_res_d;
      rsp_valid_q <= rsp_valid_d;
`ifndef ALU_RR_SCHED_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign o_alu_data_a = alu_a_q;
  assign o_alu_data_b = alu_b_q;
  assign o_alu_op     = alu_op_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_id     = rsp_id_q;
  assign o_rsp_result = rsp_res_q;

endmodule

// File: tb/tb_alu_rr_sched.sv
// Self-checking bench for alu_rr_sched (N_REQ=4, 8-bit operands).
// Directed scenarios plus a randomized run against a transaction-level model.
`timescale 1ns/1ps
module tb_alu_rr_sched;
  import alu_sched_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned ND = 8;
  localparam int unsigned NO = 6;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*ND-1:0] req_a, req_b;
  logic [N*NO-1:0] req_op;
  logic [N-1:0]  req_ready;
  logic [ND-1:0] alu_a, alu_b;
  logic [NO-1:0] alu_op;
  logic [7:0]    alu_result;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [7:0]    rsp_result;
  logic          rsp_ready;

  logic [ND-1:0] ta  [N];
  logic [ND-1:0] tbv [N];
  logic [NO-1:0] top [N];

  int n_vec = 0;
  int n_err = 0;

  localparam logic [NO-1:0] OPS [8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR,
                                        OP_XOR, OP_NOR, OP_SRA, OP_SRL};

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign req_a[k*ND +: ND]  = ta[k];
    assign req_b[k*ND +: ND]  = tbv[k];
    assign req_op[k*NO +: NO] = top[k];
  end

  alu_rr_sched dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .i_req_data_a (req_a),
    .i_req_data_b (req_b),
    .i_req_op     (req_op),
    .o_req_ready  (req_ready),
    .o_alu_data_a (alu_a),
    .o_alu_data_b (alu_b),
    .o_alu_op     (alu_op),
    .i_alu_result (alu_result),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_id     (rsp_id),
    .o_rsp_result (rsp_result),
    .i_rsp_ready  (rsp_ready)
  );

  // Reference ALU: also serves as the combinational ALU attached to the DUT
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SRA:  return $signed(a) >>> b[2:0];
      OP_SRL:  return a >> b[2:0];
      default: return a;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_op);

  // Model of the arbitration rule: first valid requester at or after p
  function automatic int pick(input logic [N-1:0] v, input int p);
`ifdef ALU_RR_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
`endif
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v == (N'(1) << i)) return i;
    return -1;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] b,
                         input logic [5:0] op);
    ta[k]  = a;
    tbv[k] = b;
    top[k] = op;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < N; k++) set_req(k, 8'h00, 8'h00, 6'h00);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    rst = 1'b0;
    tick();
    @(negedge clk);
    n_vec++;
    if ({req_ready, rsp_valid} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_hs: ready=%b rsp_valid=%b want 0000/0", req_ready, rsp_valid);
    end
    n_vec++;
    if ({alu_a, alu_b, alu_op, rsp_id, rsp_result} !== '0) begin
      n_err++;
      $display("FAIL reset_regs: a=%h b=%h op=%h id=%0d res=%h want all 0",
               alu_a, alu_b, alu_op, rsp_id, rsp_result);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    set_req(1, 8'sd5, 8'sd3, OP_ADD);
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 4'b0010) begin
      n_err++;
      $display("FAIL single_ready: got %b want 0010", req_ready);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    n_vec++;
    if ({alu_a, alu_b, alu_op, rsp_valid} !== {8'd5, 8'd3, OP_ADD, 1'b0}) begin
      n_err++;
      $display("FAIL single_alu: a=%0d b=%0d op=%h v=%b want 5/3/%h/0",
               alu_a, alu_b, alu_op, rsp_valid, OP_ADD);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 2'd1, 8'd8}) begin
      n_err++;
      $display("FAIL single_rsp: v=%b id=%0d res=%0d want 1/1/8", rsp_valid, rsp_id, rsp_result);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_idle: rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_all_valid();
    int ngr, last, w;
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, 8'(k + 1), 8'(2 * k), OP_ADD);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    ngr = 0;
    last = 0;
    for (int c = 0; c < 40 && ngr < 5; c++) begin
      @(negedge clk);
      if (req_ready !== '0) begin
        w = onehot_idx(req_ready);
        n_vec++;
`ifdef ALU_RR_SCHED_FIXED_PRIO_EN
        if (w != 0) begin
`else
        if (w != ngr % N) begin
`endif
          n_err++;
          $display("FAIL allv_order: grant %0d ready=%b", ngr, req_ready);
        end
        if (ngr > 0) begin
          n_vec++;
          if (c - last != 3) begin
            n_err++;
            $display("FAIL allv_gap: gap %0d want 3", c - last);
          end
        end
        last = c;
        ngr++;
      end
      tick();
    end
    n_vec++;
    if (ngr != 5) begin
      n_err++;
      $display("FAIL allv_count: %0d grants want 5", ngr);
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(0, 8'hF9, 8'd4, OP_SUB);
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL bp_grant: ready=%b want 0001", req_ready);
    end
    tick();
    set_req(1, 8'h30, 8'h0C, OP_OR);
    req_valid = 4'b0010;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL bp_exec_ready: ready=%b want 0000", req_ready);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if ({rsp_valid, rsp_id, rsp_result, req_ready} !== {1'b1, 2'd0, 8'hF5, 4'b0000}) begin
        n_err++;
        $display("FAIL bp_hold: cyc %0d v=%b id=%0d res=%h ready=%b want 1/0/f5/0000",
                 i, rsp_valid, rsp_id, rsp_result, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({rsp_valid, req_ready} !== {1'b1, 4'b0000}) begin
      n_err++;
      $display("FAIL bp_release: v=%b ready=%b want 1/0000", rsp_valid, req_ready);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if ({rsp_valid, req_ready} !== {1'b0, 4'b0010}) begin
      n_err++;
      $display("FAIL bp_reidle: v=%b ready=%b want 0/0010", rsp_valid, req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset_exec();
    do_reset();
    set_req(1, 8'h21, 8'h12, OP_XOR);
    set_req(3, 8'h44, 8'h04, OP_ADD);
    req_valid = 4'b1010;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 4'b0010) begin
      n_err++;
      $display("FAIL rx_grant: ready=%b want 0010", req_ready);
    end
    tick();
    req_valid = 4'b1000;
    @(negedge clk);
    n_vec++;
    if (alu_a !== 8'h21) begin
      n_err++;
      $display("FAIL rx_exec: alu_a=%h want 21", alu_a);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if ({req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result} !== '0) begin
      n_err++;
      $display("FAIL rx_clear: ready=%b a=%h b=%h op=%h v=%b id=%0d res=%h want all 0",
               req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result);
    end
    tick();
    rst = 1'b1;
    req_valid = 4'b1010;
    @(negedge clk);
    n_vec++;
    if ({req_ready, rsp_valid} !== {4'b0010, 1'b0}) begin
      n_err++;
      $display("FAIL rx_restart: ready=%b v=%b want 0010/0", req_ready, rsp_valid);
    end
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    tick();
  endtask

  task automatic test_withdraw();
    do_reset();
    set_req(0, 8'h01, 8'h02, OP_ADD);
    set_req(2, 8'h55, 8'h0F, OP_AND);
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    tick();
    req_valid = 4'b0000;
    tick();
    req_valid = 4'b0100;
    @(negedge clk);
    n_vec++;
    if ({rsp_valid, req_ready} !== {1'b1, 4'b0000}) begin
      n_err++;
      $display("FAIL wd_resp: v=%b ready=%b want 1/0000", rsp_valid, req_ready);
    end
    tick();
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_vec++;
      if (req_ready[2] !== 1'b0 || (rsp_valid === 1'b1 && rsp_id === 2'd2)) begin
        n_err++;
        $display("FAIL wd_never: cyc %0d ready=%b v=%b id=%0d want no req2 activity",
                 i, req_ready, rsp_valid, rsp_id);
      end
      tick();
    end
  endtask

  task automatic test_fixed_prio();
    int ngr, w;
    int exp_seq [3];
`ifdef ALU_RR_SCHED_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0};
`else
    exp_seq = '{0, 3, 0};
`endif
    do_reset();
    set_req(0, 8'h10, 8'h01, OP_SUB);
    set_req(3, 8'h7F, 8'h01, OP_ADD);
    req_valid = 4'b1001;
    rsp_ready = 1'b1;
    ngr = 0;
    for (int c = 0; c < 30 && ngr < 3; c++) begin
      @(negedge clk);
      if (req_ready !== '0) begin
        w = onehot_idx(req_ready);
        n_vec++;
        if (w != exp_seq[ngr]) begin
          n_err++;
          $display("FAIL prio_seq: grant %0d ready=%b want idx %0d", ngr, req_ready, exp_seq[ngr]);
        end
        ngr++;
      end
      tick();
    end
    n_vec++;
    if (ngr != 3) begin
      n_err++;
      $display("FAIL prio_count: %0d grants want 3", ngr);
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    int ptr_m, phase, w;
    logic [N-1:0] pend, exp_rdy;
    logic [7:0] ea, eb, eres;
    logic [5:0] eop;
    logic [1:0] eid;
    do_reset();
    ptr_m = 0;
    phase = 0;
    pend = '0;
    ea = '0; eb = '0; eop = '0; eid = '0; eres = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < N; k++) begin
        if (pend[k]) begin
          if ($urandom_range(0, 15) == 0) pend[k] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          set_req(k, 8'($urandom), 8'($urandom), OPS[$urandom_range(0, 7)]);
          pend[k] = 1'b1;
        end
      end
      req_valid = pend;
      rsp_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      case (phase)
        0: begin
          w = pick(pend, ptr_m);
          exp_rdy = (w >= 0) ? (N'(1) << w) : '0;
          n_vec++;
          if ({req_ready, rsp_valid, alu_a, alu_b, alu_op} !== {exp_rdy, 1'b0, ea, eb, eop}) begin
            n_err++;
            $display("FAIL rnd_idle: cyc %0d ready=%b v=%b a=%h b=%h op=%h want %b/0/%h/%h/%h",
                     cyc, req_ready, rsp_valid, alu_a, alu_b, alu_op, exp_rdy, ea, eb, eop);
          end
          if (w >= 0) begin
            ea = ta[w]; eb = tbv[w]; eop = top[w]; eid = 2'(w);
            eres = alu_fn(ea, eb, eop);
            ptr_m = (w + 1) % N;
            pend[w] = 1'b0;
            phase = 1;
          end
        end
        1: begin
          n_vec++;
          if ({req_ready, rsp_valid, alu_a, alu_b, alu_op} !== {4'b0, 1'b0, ea, eb, eop}) begin
            n_err++;
            $display("FAIL rnd_exec: cyc %0d ready=%b v=%b a=%h b=%h op=%h want 0000/0/%h/%h/%h",
                     cyc, req_ready, rsp_valid, alu_a, alu_b, alu_op, ea, eb, eop);
          end
          phase = 2;
        end
        default: begin
          n_vec++;
          if ({req_ready, rsp_valid, rsp_id, rsp_result} !== {4'b0, 1'b1, eid, eres}) begin
            n_err++;
            $display("FAIL rnd_resp: cyc %0d ready=%b v=%b id=%0d res=%h want 0000/1/%0d/%h",
                     cyc, req_ready, rsp_valid, rsp_id, rsp_result, eid, eres);
          end
          if (rsp_ready) phase = 0;
        end
      endcase
      tick();
    end
    req_valid = '0;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int k = 0; k < N; k++) set_req(k, 8'h00, 8'h00, 6'h00);
    test_reset();
    test_single();
    test_all_valid();
    test_backpressure();
    test_reset_exec();
    test_withdraw();
    test_fixed_prio();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_rr_sched.md
# alu_rr_sched

Round-robin scheduler sharing one combinational ALU among `N_REQ` requesters. Each requester offers an operand pair and opcode through a valid/ready handshake. The block grants one request at a time and drives the registered operands into the ALU. It samples the ALU result and returns it, tagged with the requester index, through a valid/ready response port. It sits between the board-level operand sources (switch/button front ends, test sequencers) and the ALU datapath.

## Interface

**Parameters**
- `N_REQ`, 4: number of requesters, 2..8.
- `NB_DATA`, 8: operand width, signed.
- `NB_OP`, 6: opcode width.
- `NB_RES`, 8: ALU result width.
- `NB_ID`, `$clog2(N_REQ)`: requester index width (localparam).

**Ports**
- `i_clk`, in, 1: single clock, rising edge.
- `i_rst`, in, 1: reset, **asynchronous, active-low**.
- `i_req_valid`, in, `N_REQ`: request valid, one bit per requester.
- `i_req_data_a`, in, `N_REQ*NB_DATA`: operand A; requester k occupies slice `[k*NB_DATA +: NB_DATA]`.
- `i_req_data_b`, in, `N_REQ*NB_DATA`: operand B, same packing as A.
- `i_req_op`, in, `N_REQ*NB_OP`: opcode, same packing.
- `o_req_ready`, out, `N_REQ`: one-hot accept pulse.
- `o_alu_data_a`, out, `NB_DATA`: registered operand A to the ALU.
- `o_alu_data_b`, out, `NB_DATA`: registered operand B to the ALU.
- `o_alu_op`, out, `NB_OP`: registered opcode to the ALU.
- `i_alu_result`, in, `NB_RES`: combinational ALU output.
- `o_rsp_valid`, out, 1: response valid.
- `o_rsp_id`, out, `NB_ID`: index of the requester being answered.
- `o_rsp_result`, out, `NB_RES`: sampled ALU result.
- `i_rsp_ready`, in, 1: consumer accepts the response.

## Operation

**State machine:** IDLE → EXEC → RESP → IDLE.

- **IDLE**
  - If any `i_req_valid` bit is set, the arbiter picks a winner k.
  - `o_req_ready[k]` is 1 for this one cycle only.
  - At the clock edge, the operands and opcode of k are latched into `o_alu_*`, k is latched into `o_rsp_id`, and the FSM moves to EXEC.
  - With no valid request, the FSM stays in IDLE.
- **EXEC**
  - `o_alu_*` are stable for the full cycle.
  - At the clock edge, `i_alu_result` is latched into `o_rsp_result` and the FSM moves to RESP.
- **RESP**
  - `o_rsp_valid` = 1.
  - The FSM holds until `i_rsp_ready` = 1, then returns to IDLE.
  - `o_rsp_id` and `o_rsp_result` stay stable while waiting.
- **Round-robin:** the priority pointer starts at the requester after the last winner and searches upward with wrap-around (N_REQ-1 wraps to 0). The pointer updates only on a grant.
- **Requester rules**
  - A requester must hold valid and its payload stable until its ready pulse.
  - Dropping valid before a grant is legal; that request is simply never granted.
  - `o_req_ready` is never asserted outside IDLE. New requests arriving during EXEC or RESP wait.
- `o_alu_*` keep their last values after a transaction completes, until the next grant.
- **Arithmetic:** the block passes operands through without modification; no sign extension or truncation.

## Timing

- **Reset values** (all registers cleared asynchronously while `i_rst` = 0):
  - state = IDLE, pointer = 0 (requester 0 highest priority).
  - `o_req_ready` = 0, `o_alu_*` = 0, `o_rsp_valid` = 0, `o_rsp_id` = 0, `o_rsp_result` = 0.
- **Latency:** grant cycle (IDLE) → EXEC → `o_rsp_valid` in the third cycle. Minimum of 3 cycles per transaction when `i_rsp_ready` is held at 1.
- **Reset mid-operation:** the in-flight transaction is dropped and no response is issued. After reset release, arbitration restarts from requester 0.
- **Simultaneous events**
  - `i_rsp_ready` = 1 in RESP together with pending requests: the FSM goes to IDLE, and the next grant happens in the following cycle (no IDLE bypass).
  - All requesters valid: each gets exactly one grant per N_REQ transactions.

## Configuration

- **`ALU_RR_SCHED_FIXED_PRIO_EN`**
  - Defined: fixed priority, with the lowest index winning. The pointer register is not built.
  - Undefined (default): round-robin as described above.

## Structure

- **Package `alu_sched_pkg`:**
  - state enum `{IDLE, EXEC, RESP}`, 2 bits;
  - default width constants (`NB_DATA`, `NB_OP`, `NB_RES`);
  - the ALU opcode constants shared with the ALU.
- **Sub-module `rr_arbiter`:**
  - inputs: request vector and pointer;
  - outputs: one-hot grant and winner index;
  - purely combinational;
  - contains the fixed-priority variant under the macro.
- **Top level:** the FSM, operand mux and registers.

## Test plan

- **Single request.** After reset, req1 is valid with A=8'sd5, B=8'sd3, op=ADD, and `i_rsp_ready`=1.
  - Required: `o_req_ready`=4'b0010 in cycle 0; `o_alu_*`=5/3/ADD in cycle 1; `o_rsp_valid`=1, id=1, result=8 in cycle 2.
- **All four valid continuously.** Required grant order is 0,1,2,3,0, with each grant 3 cycles apart.
- **Backpressure.** `i_rsp_ready`=0 for 5 cycles while in RESP.
  - Required: `o_rsp_valid` stays 1, id and result unchanged, no `o_req_ready` pulse; IDLE is re-entered the cycle after ready rises.
- **Reset during EXEC.** `i_rsp_ready`=1 throughout; `i_rst` pulsed low during EXEC.
  - Required: all outputs are 0 immediately, no response appears, and the next grant goes to the lowest valid index.
- **Valid withdrawn.** req2 is valid for 1 cycle while the FSM is in RESP, then drops.
  - Required: req2 is never granted and no response carries id 2.
- **Fixed priority.** With `ALU_RR_SCHED_FIXED_PRIO_EN` defined, req0 and req3 are held valid.
  - Required: only req0 is granted, for 3 consecutive transactions.
